// File: rtl/keycode_mem_arbiter.sv
// -----------------------------------------------------------------------------
// keycode_mem_arbiter
//
// Shares the single data-memory write port between the CPU and the PS/2
// keycode path. Keycode strobes are buffered in a small FIFO. Each buffered
// keycode is written to the KEY_ADDR mailbox as {16'h0, seq, keycode} in any
// cycle where the CPU is not writing. If the CPU keeps the port busy for
// STARVE_LIMIT cycles, the next key write is forced and the CPU is stalled.
//
// Ports
//   clk          in   system clock, rising edge
//   reset        in   asynchronous, active-high reset
//   key_code     in   [7:0]  PS/2 scan code, valid with data_ready
//   data_ready   in   one-cycle keycode strobe
//   cpu_we       in   CPU write request
//   cpu_addr     in   [31:0] CPU write byte address
//   cpu_wd       in   [31:0] CPU write data
//   cpu_stall    out  CPU write not performed this cycle; CPU must retry
//   mem_we       out  data-memory write enable
//   mem_addr     out  [31:0] data-memory byte address
//   mem_wd       out  [31:0] data-memory write data
//   fifo_count   out  number of buffered keycodes (0..FIFO_DEPTH)
//   key_dropped  out  one-cycle pulse: a keycode was lost on a full FIFO
// -----------------------------------------------------------------------------
module keycode_mem_arbiter #(
  parameter logic [31:0] KEY_ADDR     = 32'h0000_0010,
  parameter int          FIFO_DEPTH   = 4,
  parameter int          STARVE_LIMIT = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    key_code,
  input  logic                          data_ready,
  input  logic                          cpu_we,
  input  logic [31:0]                   cpu_addr,
  input  logic [31:0]                   cpu_wd,
  output logic                          cpu_stall,
  output logic                          mem_we,
  output logic [31:0]                   mem_addr,
  output logic [31:0]                   mem_wd,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          key_dropped
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [CNT_W-1:0] DEPTH = CNT_W'(FIFO_DEPTH);
  localparam logic [7:0]       LIMIT = 8'(STARVE_LIMIT);

  // FSM encoding: IDLE = FIFO empty, PEND = waiting for a free port,
  // FORCE = starvation limit reached, key write takes the port.
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_FORCE = 2'd2;

  logic [1:0]       r_state;
  logic [7:0]       r_fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_seq;
  logic [7:0]       r_starve;
  logic             r_key_dropped;

  logic             w_kgnt;
  logic             w_full;
  logic             w_push;
  logic             w_pop;
  logic [7:0]       w_head;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_starve_nxt;
  logic [1:0]       w_state_nxt;

  // ---------------------------------------------------------------------------
  // Grant and FIFO handshake
  // ---------------------------------------------------------------------------
  always_comb begin
    w_full = (r_count == DEPTH);
    w_kgnt = ((r_state == S_PEND) && !cpu_we) || (r_state == S_FORCE);
    w_pop  = w_kgnt;
    // A full FIFO still accepts a key when the head leaves on the same edge.
    w_push = data_ready && (!w_full || w_pop);
    w_head = r_fifo_mem[r_rd_ptr];
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a value on every path
  // (default first), otherwise synthesis infers a latch.
  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + CNT_W'(1);
      2'b01:   w_count_nxt = r_count - CNT_W'(1);
      default: w_count_nxt = r_count;
    endcase

    w_starve_nxt = r_starve;
    if (w_kgnt || (r_state == S_IDLE)) begin
      w_starve_nxt = 8'd0;
    end else if ((r_state == S_PEND) && cpu_we && (r_starve < LIMIT)) begin
      w_starve_nxt = r_starve + 8'd1;
    end

    // State follows directly from occupancy and the starvation count.
    if (w_count_nxt == '0) begin
      w_state_nxt = S_IDLE;
    end else if (w_starve_nxt == LIMIT) begin
      w_state_nxt = S_FORCE;
    end else begin
      w_state_nxt = S_PEND;
    end
  end

  // ---------------------------------------------------------------------------
  // Control registers
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_rd_ptr      <= '0;
      r_wr_ptr      <= '0;
      r_count       <= '0;
      r_seq         <= 8'd0;
      r_starve      <= 8'd0;
      r_key_dropped <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_count       <= w_count_nxt;
      r_starve      <= w_starve_nxt;
      r_key_dropped <= data_ready && !w_push;
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
        r_seq    <= r_seq + 8'd1;
      end
    end
  end

  // NOTE: the FIFO storage is deliberately not reset; the pointers and count
  // define which entries are valid, so clearing the array is unnecessary.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_fifo_mem[r_wr_ptr] <= key_code;
    end
  end

  // ---------------------------------------------------------------------------
  // Memory port mux
  // ---------------------------------------------------------------------------
  always_comb begin
    if (w_kgnt) begin
      mem_we   = 1'b1;
      mem_addr = KEY_ADDR;
      mem_wd   = {16'h0000, r_seq, w_head};
    end else begin
      mem_we   = cpu_we;
      mem_addr = cpu_addr;
      mem_wd   = cpu_wd;
    end
  end

  assign cpu_stall   = w_kgnt && cpu_we;
  assign fifo_count  = r_count;
  assign key_dropped = r_key_dropped;

endmodule

// File: tb/tb_keycode_mem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_keycode_mem_arbiter
//
// Directed scenarios with literal expectations, followed by randomized traffic.
// A queue-based reference model is checked against every DUT output once per
// cycle, shortly before the rising edge.
// -----------------------------------------------------------------------------
module tb_keycode_mem_arbiter;

  localparam int          DEPTH = 4;
  localparam int          LIMIT = 8;
  localparam logic [31:0] KADDR = 32'h0000_0010;

  logic        clk;
  logic        reset;
  logic [7:0]  key_code;
  logic        data_ready;
  logic        cpu_we;
  logic [31:0] cpu_addr;
  logic [31:0] cpu_wd;
  logic        cpu_stall;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic [2:0]  fifo_count;
  logic        key_dropped;

  int n_checks = 0;
  int n_errors = 0;

  keycode_mem_arbiter #(
    .KEY_ADDR     (KADDR),
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .key_code    (key_code),
    .data_ready  (data_ready),
    .cpu_we      (cpu_we),
    .cpu_addr    (cpu_addr),
    .cpu_wd      (cpu_wd),
    .cpu_stall   (cpu_stall),
    .mem_we      (mem_we),
    .mem_addr    (mem_addr),
    .mem_wd      (mem_wd),
    .fifo_count  (fifo_count),
    .key_dropped (key_dropped)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: a queue of pending keys, a sequence number and a count of
  // cycles the key path has been refused while keys were waiting.
  // ---------------------------------------------------------------------------
  logic [7:0] mq[$];
  int         m_seq    = 0;
  int         m_starve = 0;
  bit         m_drop   = 1'b0;

  task automatic model_cycle();
    bit          g;
    bit          was_empty;
    bit          was_full;
    logic [7:0]  head;
    logic [31:0] e_addr;
    logic [31:0] e_wd;
    logic        e_we;
    logic [7:0]  seq8;
    if (reset) begin
      mq.delete();
      m_seq    = 0;
      m_starve = 0;
      m_drop   = 1'b0;
      check("rst_count", 32'(fifo_count), 32'd0);
      check("rst_drop",  32'(key_dropped), 32'd0);
      check("rst_stall", 32'(cpu_stall), 32'd0);
      check("rst_we",    32'(mem_we), 32'(cpu_we));
      check("rst_addr",  mem_addr, cpu_addr);
      check("rst_wd",    mem_wd, cpu_wd);
    end else begin
      was_empty = (mq.size() == 0);
      was_full  = (mq.size() == DEPTH);
      head      = was_empty ? 8'h00 : mq[0];
      seq8      = 8'(m_seq);
      // The key path wins when the CPU is quiet, or when it has waited too long.
      g = !was_empty && (!cpu_we || (m_starve == LIMIT));
      e_we   = g ? 1'b1 : cpu_we;
      e_addr = g ? KADDR : cpu_addr;
      e_wd   = g ? {16'h0000, seq8, head} : cpu_wd;
      check("m_we",    32'(mem_we), 32'(e_we));
      check("m_addr",  mem_addr, e_addr);
      check("m_wd",    mem_wd, e_wd);
      check("m_stall", 32'(cpu_stall), 32'(g && cpu_we));
      check("m_count", 32'(fifo_count), 32'(mq.size()));
      check("m_drop",  32'(key_dropped), 32'(m_drop));
      // Advance to the state after the coming edge.
      if (g) begin
        void'(mq.pop_front());
        m_seq = (m_seq + 1) % 256;
      end
      m_drop = data_ready && was_full && !g;
      if (data_ready && !(was_full && !g)) mq.push_back(key_code);
      if (g || was_empty) m_starve = 0;
      else if (m_starve < LIMIT) m_starve = m_starve + 1;
    end
  endtask

  // Compare process: runs 2 time units before every rising edge.
  always begin
    @(negedge clk);
    #3;
    model_cycle();
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Applies inputs just after a rising edge and returns at the following
  // falling edge, where outputs for that cycle can be inspected.
  task automatic step(input logic rst, input logic dr, input logic [7:0] kc,
                      input logic we, input logic [31:0] a, input logic [31:0] d);
    @(posedge clk);
    #1;
    reset      = rst;
    data_ready = dr;
    key_code   = kc;
    cpu_we     = we;
    cpu_addr   = a;
    cpu_wd     = d;
    @(negedge clk);
  endtask

  task automatic do_reset();
    step(1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    check("reset_count", 32'(fifo_count), 32'd0);
    check("reset_stall", 32'(cpu_stall), 32'd0);
  endtask

  logic [7:0] got[$];
  int         budget;

  initial begin
    reset      = 1'b1;
    data_ready = 1'b0;
    key_code   = 8'h00;
    cpu_we     = 1'b0;
    cpu_addr   = 32'h0;
    cpu_wd     = 32'h0;

    // --- Scenario 1: single key, one-cycle latency, seq advances ------------
    do_reset();
    step(1'b0, 1'b1, 8'h6B, 1'b0, 32'h0, 32'h0);
    check("s1_no_bypass", 32'(mem_we), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    check("s1_we",    32'(mem_we), 32'd1);
    check("s1_addr",  mem_addr, 32'h0000_0010);
    check("s1_wd",    mem_wd, 32'h0000_006B);
    check("s1_stall", 32'(cpu_stall), 32'd0);
    step(1'b0, 1'b1, 8'h11, 1'b0, 32'h0, 32'h0);
    check("s1_idle_after", 32'(mem_we), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    check("s1_seq1_wd", mem_wd, 32'h0000_0111);

    // --- Scenario 2: back-to-back keys, CPU idle --------------------------
    do_reset();
    step(1'b0, 1'b1, 8'h6B, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b1, 8'h74, 1'b0, 32'h0, 32'h0);
    check("s2_wd0", mem_wd, 32'h0000_006B);
    check("s2_cnt0", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b1, 8'h75, 1'b0, 32'h0, 32'h0);
    check("s2_wd1", mem_wd, 32'h0000_0174);
    check("s2_cnt1", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    check("s2_wd2", mem_wd, 32'h0000_0275);
    check("s2_cnt2", 32'(fifo_count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    check("s2_done_we", 32'(mem_we), 32'd0);
    check("s2_done_cnt", 32'(fifo_count), 32'd0);

    // --- Scenario 3: starvation forces a key write after 8 denied cycles ---
    do_reset();
    step(1'b0, 1'b1, 8'h5A, 1'b1, 32'h100, 32'hCAFE_0001);
    for (int i = 0; i < LIMIT; i++) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 32'h100, 32'hCAFE_0001);
      check("s3_denied_stall", 32'(cpu_stall), 32'd0);
      check("s3_denied_addr", mem_addr, 32'h100);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'h100, 32'hCAFE_0001);
    check("s3_force_stall", 32'(cpu_stall), 32'd1);
    check("s3_force_addr", mem_addr, 32'h0000_0010);
    check("s3_force_wd", mem_wd, 32'h0000_005A);
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'h100, 32'hCAFE_0001);
    check("s3_after_stall", 32'(cpu_stall), 32'd0);
    check("s3_after_cnt", 32'(fifo_count), 32'd0);

    // --- Scenario 4: overflow drops the 5th key, then drain in order -------
    do_reset();
    for (int k = 1; k <= 5; k++) begin
      step(1'b0, 1'b1, 8'(k), 1'b1, 32'h200, 32'hDEAD_0000);
    end
    check("s4_full_cnt", 32'(fifo_count), 32'd4);
    check("s4_no_drop_yet", 32'(key_dropped), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'h200, 32'hDEAD_0000);
    check("s4_drop_pulse", 32'(key_dropped), 32'd1);
    check("s4_cnt_after", 32'(fifo_count), 32'd4);
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'h200, 32'hDEAD_0000);
    check("s4_drop_once", 32'(key_dropped), 32'd0);
    got.delete();
    budget = 100;
    while (got.size() < 4 && budget > 0) begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 32'h200, 32'hDEAD_0000);
      if (cpu_stall) got.push_back(mem_wd[7:0]);
      budget--;
    end
    check("s4_drain_timeout", 32'(got.size()), 32'd4);
    for (int i = 0; i < got.size(); i++) begin
      check("s4_drain_order", 32'(got[i]), 32'(i + 1));
    end

    // --- Scenario 5: full FIFO, push on the forced-pop edge ----------------
    do_reset();
    for (int k = 0; k < 4; k++) begin
      step(1'b0, 1'b1, 8'h20 + 8'(k), 1'b1, 32'h300, 32'h0);
    end
    budget = 20;
    do begin
      step(1'b0, 1'b0, 8'h00, 1'b1, 32'h300, 32'h0);
      budget--;
    end while (!cpu_stall && budget > 0);
    check("s5_force_seen", 32'(cpu_stall), 32'd1);
    check("s5_full_before", 32'(fifo_count), 32'd4);
    #1;
    data_ready = 1'b1;
    key_code   = 8'hAA;
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'h300, 32'h0);
    check("s5_no_drop", 32'(key_dropped), 32'd0);
    check("s5_cnt_kept", 32'(fifo_count), 32'd4);

    // --- Scenario 6: async reset with keys queued ---------------------------
    do_reset();
    for (int k = 0; k < 3; k++) begin
      step(1'b0, 1'b1, 8'h40 + 8'(k), 1'b1, 32'h400, 32'h0);
    end
    step(1'b0, 1'b0, 8'h00, 1'b1, 32'h400, 32'h0);
    check("s6_queued", 32'(fifo_count), 32'd3);
    @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("s6_async_cnt", 32'(fifo_count), 32'd0);
    check("s6_async_stall", 32'(cpu_stall), 32'd0);
    check("s6_async_addr", mem_addr, 32'h400);
    step(1'b0, 1'b1, 8'h33, 1'b0, 32'h0, 32'h0);
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);
    check("s6_seq0_wd", mem_wd, 32'h0000_0033);

    // --- Randomized traffic -------------------------------------------------
    for (int c = 0; c < 3000; c++) begin
      logic busy_phase;
      logic rst_now;
      logic dr;
      logic we;
      busy_phase = ((c / 200) % 2) == 0;
      rst_now    = ($urandom_range(0, 599) == 0);
      dr         = ($urandom_range(0, 9) < 4);
      we         = busy_phase ? ($urandom_range(0, 9) < 9) : ($urandom_range(0, 9) < 3);
      step(rst_now, dr, 8'($urandom), we, $urandom, $urandom);
    end
    step(1'b0, 1'b0, 8'h00, 1'b0, 32'h0, 32'h0);

    @(posedge clk);
    #1;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
